toplayici: RTL and testbench
============================

TOPLAYICI -- requirements
Module: toplayici

Interface
REQ-001 clk  input  1  sole clock, all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately.
REQ-003 basla  input  1  start strobe; sampled only in IDLE.
REQ-004 sayi1  input  32  IEEE-754 single operand A (typically the carpici product); captured on accepted basla.
REQ-005 sayi2  input  32  IEEE-754 single operand B; captured on accepted basla.
REQ-006 mesgul  output  1  high from the cycle after basla is accepted until hazir is asserted, inclusive.
REQ-007 hazir  output  1  one-cycle pulse; sonuc is valid in that cycle.
REQ-008 sonuc  output  32  IEEE-754 single sum A+B, held stable until the next hazir.

Function
REQ-009 FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND; ROUND returns to IDLE.
REQ-010 IDLE->UNPACK when basla=1: capture operands, mesgul rises next edge.
REQ-011 Fixed latency: basla sampled at edge N -> hazir=1 in the cycle after edge N+5, every operation, special cases included.
REQ-012 basla while mesgul=1 is ignored; operands are not recaptured.
REQ-013 basla in the same cycle as hazir is ignored (FSM is not yet in IDLE).
REQ-014 UNPACK: split sign/exponent/fraction, insert hidden bit for normals, classify zero/subnormal/inf/NaN.
REQ-015 ALIGN: right-shift the smaller-magnitude significand by exponent difference in one cycle, keep guard, round and sticky bits; shift >=27 collapses to sticky only.
REQ-016 ADD: same signs add magnitudes, different signs subtract smaller from larger; result sign is the larger-magnitude sign.
REQ-017 NORM: one-cycle leading-zero count and shift; carry-out shifts right 1 and increments exponent.
REQ-018 ROUND: round-to-nearest-even; a rounding carry renormalizes and may overflow.
REQ-019 Exact zero from unlike signs yields +0 (0x00000000); (-0)+(-0) yields 0x80000000.
REQ-020 Any NaN operand -> 0x7FC00000.
REQ-021 +inf + -inf -> 0x7FC00000; inf + finite -> that inf.
REQ-022 Exponent overflow after rounding -> signed infinity (0x7F800000 / 0xFF800000).
REQ-023 Reset mid-operation aborts; no hazir for the aborted operation.

Reset
REQ-024 While reset=0: FSM=IDLE, mesgul=0, hazir=0, sonuc=0x00000000, operand registers=0.
REQ-025 First basla accepted at the first rising edge with reset=1.

Configuration
REQ-026 Macro TOPLAYICI_DENORMAL_EN defined: subnormal inputs use hidden bit 0 and exponent 1; results below min normal are emitted as subnormals with correct rounding.
REQ-027 Macro undefined: subnormal inputs are treated as signed zero; subnormal results are flushed to signed zero; latency unchanged.

Structure
REQ-028 Shared package fp_paket holds: field widths (exp 8, frac 23, bias 127), QNAN=0x7FC00000, POS_INF/NEG_INF constants, FSM state enum, operand class enum; carpici reuses it.
REQ-029 One sub-module, fp_lzc, a combinational 28-bit leading-zero counter used by NORM.
REQ-030 Total RTL for toplayici plus fp_lzc is 120-400 lines.

Verification
REQ-031 0x3F800000 + 0x3F800000 -> 0x40000000; hazir exactly 6 cycles after basla edge, mesgul high 6 cycles.
REQ-032 0x40400000 + 0xBF800000 -> 0x40000000; 0x3F800000 + 0xBF800000 -> 0x00000000.
REQ-033 0x3F800000 + 0x33800000 (tie) -> 0x3F800000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-034 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7FC00000 + 0x41200000 -> 0x7FC00000; 0xFF800000 + 0x41200000 -> 0xFF800000.
REQ-035 0x00000001 + 0x00000001 -> 0x00000002 with TOPLAYICI_DENORMAL_EN, 0x00000000 without.
REQ-036 basla re-pulsed during ALIGN is ignored (one hazir only); reset=0 pulsed during ADD -> no hazir, sonuc=0, next basla completes normally.

Source files
------------

// File: rtl/toplayici_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fp_paket
//  Description : Shared single-precision floating-point definitions: field
//                widths, special encodings, FSM state and operand class
//                enums, and an unpack/classify helper pair. Also used by the
//                carpici multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_paket;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = FRAC_W + 1;   // significand with hidden bit
    localparam int EXT_W  = SIG_W + 3;    // significand plus guard/round/sticky

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5
    } fp_state_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_e;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   expo;
        logic [SIG_W-1:0]   sig;
    } fp_num_t;

    function automatic fp_class_e fp_classify(input logic [31:0] v);
        fp_class_e c;
        if (v[30:23] == 8'hFF)
            c = (v[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else if (v[30:23] == 8'h00)
            c = (v[22:0] != 23'd0) ? CLS_SUB : CLS_ZERO;
        else
            c = CLS_NORM;
        return c;
    endfunction

    // Subnormals come out with exponent 1 and hidden bit 0; zero is all-zero.
    function automatic fp_num_t fp_unpack(input logic [31:0] v);
        fp_num_t u;
        u.sign = v[31];
        u.expo = v[30:23];
        u.sig  = {1'b1, v[22:0]};
        if (v[30:23] == 8'h00) begin
            u.expo = (v[22:0] != 23'd0) ? 8'd1 : 8'd0;
            u.sig  = {1'b0, v[22:0]};
        end
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toplayici_if.sv
`default_nettype none
// ============================================================================
//  Interface   : toplayici_if
//  Description : Start/operand/result handshake bundle of the FP adder.
//                master drives basla/sayi1/sayi2, slave (the adder) returns
//                mesgul/hazir/sonuc.
//  Revision    : 1.0 - initial release
// ============================================================================
interface toplayici_if;
    logic        basla;
    logic [31:0] sayi1;
    logic [31:0] sayi2;
    logic        mesgul;
    logic        hazir;
    logic [31:0] sonuc;

    modport master (output basla, sayi1, sayi2, input  mesgul, hazir, sonuc);
    modport slave  (input  basla, sayi1, sayi2, output mesgul, hazir, sonuc);
endinterface
`default_nettype wire

// File: rtl/toplayici_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter. An all-zero input
//                returns WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = 5
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] w_cnt;
    logic             w_found;

    // Priority scan from the MSB; first set bit fixes the count.
    always_comb begin
        w_cnt   = CNT_W'(WIDTH);
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && i_val[i]) begin
                w_cnt   = CNT_W'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    assign o_cnt = w_cnt;
endmodule
`default_nettype wire

// File: rtl/toplayici.sv
`default_nettype none
// ============================================================================
//  Module      : toplayici
//  Description : Multi-cycle IEEE-754 single-precision adder. Six-state FSM
//                (IDLE, UNPACK, ALIGN, ADD, NORM, ROUND) with fixed latency:
//                hazir pulses in the cycle after the fifth edge following the
//                accepting edge. Round-to-nearest-even.
//                Build option TOPLAYICI_DENORMAL_EN: keep subnormal inputs
//                and emit subnormal results; otherwise both flush to signed
//                zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module toplayici
    import fp_paket::*;
(
    input  logic        clk,
    input  logic        reset,
    toplayici_if.slave  bus
);
    localparam logic [2:0] c_IDLE   = ST_IDLE;
    localparam logic [2:0] c_UNPACK = ST_UNPACK;
    localparam logic [2:0] c_ALIGN  = ST_ALIGN;
    localparam logic [2:0] c_ADD    = ST_ADD;
    localparam logic [2:0] c_NORM   = ST_NORM;
    localparam logic [2:0] c_ROUND  = ST_ROUND;

    logic [2:0]       r_state;
    logic             r_mesgul;
    logic             r_hazir;
    logic [31:0]      r_sonuc;
    logic [31:0]      r_a;
    logic [31:0]      r_b;

    // UNPACK stage
    fp_num_t          w_ua, w_ub;
    fp_class_e        w_ca, w_cb;
    logic             w_spec;
    logic [31:0]      w_spec_val;
    fp_num_t          r_ua, r_ub;
    logic             r_spec;
    logic [31:0]      r_spec_val;

    // ALIGN stage
    fp_num_t          w_big, w_small;
    logic [7:0]       w_diff;
    logic [EXT_W-1:0] w_sm_ext, w_sm_shift, w_sm_lost, w_sm_aligned;
    logic [EXT_W-1:0] r_big_ext, r_sm_ext;
    logic [7:0]       r_exp;
    logic             r_sign, r_sub, r_zsign;

    // ADD stage
    logic [EXT_W:0]   r_sum;

    // NORM stage
    logic [4:0]       w_lz, w_sh;
    logic [9:0]       w_e_big;
    logic [EXT_W-1:0] w_nm;
    logic [9:0]       w_ne;
    logic             w_nzero, w_nzsign;
    logic [EXT_W-1:0] r_m;
    logic [9:0]       r_e;
    logic             r_zero, r_zs;

    // ROUND stage
    logic             w_up;
    logic [SIG_W:0]   w_kr;
    logic [SIG_W-1:0] w_rsig;
    logic [9:0]       w_re;
    logic [31:0]      w_res;

    // Control FSM: start acceptance, stage sequencing, mesgul/hazir flags.
    // basla is refused during the hazir cycle so back-to-back starts cannot
    // overlap the result pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_mesgul <= 1'b0;
            r_hazir  <= 1'b0;
            r_sonuc  <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
        end else begin
            r_hazir <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_hazir)
                        r_mesgul <= 1'b0;
                    else if (bus.basla) begin
                        r_a      <= bus.sayi1;
                        r_b      <= bus.sayi2;
                        r_mesgul <= 1'b1;
                        r_state  <= c_UNPACK;
                    end
                end
                c_UNPACK: r_state <= c_ALIGN;
                c_ALIGN:  r_state <= c_ADD;
                c_ADD:    r_state <= c_NORM;
                c_NORM:   r_state <= c_ROUND;
                c_ROUND: begin
                    r_sonuc <= w_res;
                    r_hazir <= 1'b1;
                    r_state <= c_IDLE;
                end
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    // Field split and classification; subnormals become signed zero unless
    // denormal support is built in.
    always_comb begin
        w_ua = fp_unpack(r_a);
        w_ub = fp_unpack(r_b);
        w_ca = fp_classify(r_a);
        w_cb = fp_classify(r_b);
`ifndef TOPLAYICI_DENORMAL_EN
        if (w_ca == CLS_SUB) begin
            w_ua.expo = 8'd0;
            w_ua.sig  = '0;
        end
        if (w_cb == CLS_SUB) begin
            w_ub.expo = 8'd0;
            w_ub.sig  = '0;
        end
`endif
    end

    // NaN/infinity results bypass the arithmetic path entirely.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_val = QNAN;
        if (w_ca == CLS_NAN || w_cb == CLS_NAN) begin
            w_spec = 1'b1;
        end else if (w_ca == CLS_INF && w_cb == CLS_INF) begin
            w_spec     = 1'b1;
            w_spec_val = (r_a[31] != r_b[31]) ? QNAN : (r_a[31] ? NEG_INF : POS_INF);
        end else if (w_ca == CLS_INF) begin
            w_spec     = 1'b1;
            w_spec_val = r_a[31] ? NEG_INF : POS_INF;
        end else if (w_cb == CLS_INF) begin
            w_spec     = 1'b1;
            w_spec_val = r_b[31] ? NEG_INF : POS_INF;
        end
    end

    // UNPACK register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ua       <= '0;
            r_ub       <= '0;
            r_spec     <= 1'b0;
            r_spec_val <= 32'd0;
        end else if (r_state == c_UNPACK) begin
            r_ua       <= w_ua;
            r_ub       <= w_ub;
            r_spec     <= w_spec;
            r_spec_val <= w_spec_val;
        end
    end

    // Order operands by magnitude and shift the smaller one right, folding
    // every bit shifted past the round position into the sticky bit.
    always_comb begin
        if ({r_ua.expo, r_ua.sig} >= {r_ub.expo, r_ub.sig}) begin
            w_big   = r_ua;
            w_small = r_ub;
        end else begin
            w_big   = r_ub;
            w_small = r_ua;
        end
        w_diff       = w_big.expo - w_small.expo;
        w_sm_ext     = {w_small.sig, 3'b000};
        w_sm_shift   = w_sm_ext >> w_diff;
        w_sm_lost    = w_sm_ext & ~({EXT_W{1'b1}} << w_diff);
        w_sm_aligned = {w_sm_shift[EXT_W-1:1], w_sm_shift[0] | (|w_sm_lost)};
    end

    // ALIGN register stage; an exact-zero sum takes +0 for unlike signs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_big_ext <= '0;
            r_sm_ext  <= '0;
            r_exp     <= 8'd0;
            r_sign    <= 1'b0;
            r_sub     <= 1'b0;
            r_zsign   <= 1'b0;
        end else if (r_state == c_ALIGN) begin
            r_big_ext <= {w_big.sig, 3'b000};
            r_sm_ext  <= w_sm_aligned;
            r_exp     <= w_big.expo;
            r_sign    <= w_big.sign;
            r_sub     <= r_ua.sign ^ r_ub.sign;
            r_zsign   <= r_ua.sign & r_ub.sign;
        end
    end

    // Magnitude add or subtract (larger minus smaller, never negative).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_sum <= '0;
        else if (r_state == c_ADD)
            r_sum <= r_sub ? ({1'b0, r_big_ext} - {1'b0, r_sm_ext})
                           : ({1'b0, r_big_ext} + {1'b0, r_sm_ext});
    end

    fp_lzc #(.WIDTH(EXT_W + 1), .CNT_W(5)) u_lzc (
        .i_val (r_sum),
        .o_cnt (w_lz)
    );

    assign w_sh    = w_lz - 5'd1;
    assign w_e_big = {2'b00, r_exp};

    // Normalise so the leading one sits at the hidden-bit position. A left
    // shift that would push the exponent below 1 is clamped (subnormal) or
    // flushed to signed zero, depending on the build.
    always_comb begin
        w_nm     = r_sum[EXT_W-1:0];
        w_ne     = w_e_big;
        w_nzero  = 1'b0;
        w_nzsign = r_zsign;
        if (r_sum == '0) begin
            w_nzero = 1'b1;
        end else if (r_sum[EXT_W]) begin
            w_nm = {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
            w_ne = w_e_big + 10'd1;
        end else if ({5'd0, w_sh} >= w_e_big) begin
`ifdef TOPLAYICI_DENORMAL_EN
            w_nm = r_sum[EXT_W-1:0] << (w_e_big[4:0] - 5'd1);
            w_ne = 10'd1;
`else
            w_nzero  = 1'b1;
            w_nzsign = r_sign;
`endif
        end else begin
            w_nm = r_sum[EXT_W-1:0] << w_sh;
            w_ne = w_e_big - {5'd0, w_sh};
        end
    end

    // NORM register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m    <= '0;
            r_e    <= 10'd0;
            r_zero <= 1'b0;
            r_zs   <= 1'b0;
        end else if (r_state == c_NORM) begin
            r_m    <= w_nm;
            r_e    <= w_ne;
            r_zero <= w_nzero;
            r_zs   <= w_nzsign;
        end
    end

    // Round to nearest even, renormalise on carry, saturate to infinity and
    // pick the final encoding. A clear hidden bit encodes exponent field 0.
    always_comb begin
        w_up = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        w_kr = {1'b0, r_m[EXT_W-1:3]} + {{SIG_W{1'b0}}, w_up};
        if (w_kr[SIG_W]) begin
            w_rsig = w_kr[SIG_W:1];
            w_re   = r_e + 10'd1;
        end else begin
            w_rsig = w_kr[SIG_W-1:0];
            w_re   = r_e;
        end
        if (r_spec)
            w_res = r_spec_val;
        else if (r_zero)
            w_res = {r_zs, 31'd0};
        else if (w_re >= 10'd255)
            w_res = r_sign ? NEG_INF : POS_INF;
        else
            w_res = {r_sign, (w_rsig[SIG_W-1] ? w_re[7:0] : 8'd0), w_rsig[FRAC_W-1:0]};
    end

    assign bus.mesgul = r_mesgul;
    assign bus.hazir  = r_hazir;
    assign bus.sonuc  = r_sonuc;

endmodule
`default_nettype wire

// File: tb/tb_toplayici.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toplayici
//  Description : Directed self-checking bench for the toplayici FP adder.
//                Expected values for subnormal cases follow the
//                TOPLAYICI_DENORMAL_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toplayici;

`ifdef TOPLAYICI_DENORMAL_EN
    localparam logic [31:0] c_EXP_TINY2 = 32'h0000_0002;
    localparam logic [31:0] c_EXP_DIFF1 = 32'h0000_0001;
    localparam logic [31:0] c_EXP_MINUS = 32'h007F_FFFF;
`else
    localparam logic [31:0] c_EXP_TINY2 = 32'h0000_0000;
    localparam logic [31:0] c_EXP_DIFF1 = 32'h0000_0000;
    localparam logic [31:0] c_EXP_MINUS = 32'h0080_0000;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    toplayici_if bus();

    toplayici u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drive one operation from a negedge; return result, latency (cycles
    // from the accepting edge to hazir, -1 on timeout), mesgul cycle count
    // and the flags one cycle after hazir.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy,
                          output logic tail_m, output logic tail_h);
        bus.sayi1 = a;
        bus.sayi2 = b;
        bus.basla = 1'b1;
        @(posedge clk);
        #1;
        bus.basla = 1'b0;
        lat  = -1;
        busy = 0;
        res  = 32'hDEAD_BEEF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mesgul === 1'b1) busy++;
            if (bus.hazir === 1'b1) begin
                lat = c;
                res = bus.sonuc;
                break;
            end
        end
        @(negedge clk);
        tail_m = bus.mesgul;
        tail_h = bus.hazir;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.basla = 1'b0;
        bus.sayi1 = 32'd0;
        bus.sayi2 = 32'd0;
        repeat (3) @(negedge clk);
        bus.basla = 1'b1;
        bus.sayi1 = 32'h3F80_0000;
        bus.sayi2 = 32'h3F80_0000;
        @(negedge clk);
        checks++;
        if (bus.mesgul !== 1'b0) begin errors++; $display("FAIL reset_mesgul: got %b expected 0", bus.mesgul); end
        checks++;
        if (bus.hazir !== 1'b0) begin errors++; $display("FAIL reset_hazir: got %b expected 0", bus.hazir); end
        checks++;
        if (bus.sonuc !== 32'h0) begin errors++; $display("FAIL reset_sonuc: got %h expected 00000000", bus.sonuc); end
        bus.basla = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int          lat, busy;
        logic        tm, th;
        run_op(32'h3F80_0000, 32'h3F80_0000, res, lat, busy, tm, th);
        checks++;
        if (res !== 32'h4000_0000) begin errors++; $display("FAIL basic_sum: got %h expected 40000000", res); end
        checks++;
        if (lat != 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", lat); end
        checks++;
        if (busy != 6) begin errors++; $display("FAIL basic_mesgul_cycles: got %0d expected 6", busy); end
        checks++;
        if (tm !== 1'b0) begin errors++; $display("FAIL basic_mesgul_after: got %b expected 0", tm); end
        checks++;
        if (th !== 1'b0) begin errors++; $display("FAIL basic_hazir_pulse: got %b expected 0", th); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sonuc !== 32'h4000_0000) begin errors++; $display("FAIL basic_sonuc_held: got %h expected 40000000", bus.sonuc); end
    endtask

    task automatic run_table(input string tag, input logic [31:0] va[], input logic [31:0] vb[],
                             input logic [31:0] ve[]);
        logic [31:0] res;
        int          lat, busy;
        logic        tm, th;
        for (int i = 0; i < va.size(); i++) begin
            run_op(va[i], vb[i], res, lat, busy, tm, th);
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("FAIL %s[%0d] %h+%h: got %h expected %h", tag, i, va[i], vb[i], res, ve[i]);
            end
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL %s[%0d]_latency: got %0d expected 6", tag, i, lat);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] va[] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF,
                              32'h8000_0000, 32'h3FC0_0000, 32'h4B80_0000, 32'h3F80_0000,
                              32'h3F80_0000, 32'hFF7F_FFFF, 32'h0000_0000, 32'h4120_0000};
        logic [31:0] vb[] = '{32'hBF80_0000, 32'hBF80_0000, 32'h3380_0000, 32'h7F7F_FFFF,
                              32'h8000_0000, 32'h4020_0000, 32'h4040_0000, 32'hB300_0000,
                              32'hBF80_0001, 32'hFF7F_FFFF, 32'h8000_0000, 32'hC130_0000};
        logic [31:0] ve[] = '{32'h4000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000,
                              32'h8000_0000, 32'h4080_0000, 32'h4B80_0002, 32'h3F80_0000,
                              32'hB400_0000, 32'hFF80_0000, 32'h0000_0000, 32'hBF80_0000};
        run_table("arith", va, vb, ve);
    endtask

    task automatic test_special();
        logic [31:0] va[] = '{32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000,
                              32'h4120_0000, 32'h7F80_0000, 32'hFFC0_0001};
        logic [31:0] vb[] = '{32'hFF80_0000, 32'h4120_0000, 32'h4120_0000,
                              32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000};
        logic [31:0] ve[] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
                              32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000};
        run_table("special", va, vb, ve);
    endtask

    task automatic test_denormal();
        logic [31:0] va[] = '{32'h0000_0001, 32'h0080_0001, 32'h0080_0000,
                              32'h0000_0001, 32'h0080_0000};
        logic [31:0] vb[] = '{32'h0000_0001, 32'h8080_0000, 32'h0080_0000,
                              32'h8000_0001, 32'h8000_0001};
        logic [31:0] ve[5];
        ve[0] = c_EXP_TINY2;
        ve[1] = c_EXP_DIFF1;
        ve[2] = 32'h0100_0000;
        ve[3] = 32'h0000_0000;
        ve[4] = c_EXP_MINUS;
        run_table("denormal", va, vb, ve);
    endtask

    task automatic test_ignore_basla();
        int          hz = 0;
        int          first = -1;
        logic [31:0] res = 32'hDEAD_BEEF;
        bus.sayi1 = 32'h3F80_0000;
        bus.sayi2 = 32'h3F80_0000;
        bus.basla = 1'b1;
        @(posedge clk);
        #1;
        bus.basla = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.hazir === 1'b1) begin
                hz++;
                if (first < 0) begin first = c; res = bus.sonuc; end
            end
            if (c == 2) begin
                bus.sayi1 = 32'h4120_0000;
                bus.sayi2 = 32'h4120_0000;
                bus.basla = 1'b1;
            end else begin
                bus.basla = 1'b0;
            end
        end
        checks++;
        if (hz != 1) begin errors++; $display("FAIL ignore_hazir_count: got %0d expected 1", hz); end
        checks++;
        if (first != 6) begin errors++; $display("FAIL ignore_latency: got %0d expected 6", first); end
        checks++;
        if (res !== 32'h4000_0000) begin errors++; $display("FAIL ignore_result: got %h expected 40000000", res); end
    endtask

    task automatic test_basla_at_hazir();
        int hz = 0;
        int got = 0;
        bus.sayi1 = 32'h4000_0000;
        bus.sayi2 = 32'h4000_0000;
        bus.basla = 1'b1;
        @(posedge clk);
        #1;
        bus.basla = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.hazir === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL hazir_basla_seen: got %0d expected 1", got); end
        bus.sayi1 = 32'h3F80_0000;
        bus.sayi2 = 32'h3F80_0000;
        bus.basla = 1'b1;
        @(negedge clk);
        bus.basla = 1'b0;
        checks++;
        if (bus.mesgul !== 1'b0) begin errors++; $display("FAIL hazir_basla_mesgul: got %b expected 0", bus.mesgul); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.hazir === 1'b1) hz++;
        end
        checks++;
        if (hz != 0) begin errors++; $display("FAIL hazir_basla_extra: got %0d expected 0", hz); end
        checks++;
        if (bus.sonuc !== 32'h4080_0000) begin errors++; $display("FAIL hazir_basla_sonuc: got %h expected 40800000", bus.sonuc); end
    endtask

    task automatic test_reset_abort();
        int          hz = 0;
        logic [31:0] res;
        int          lat, busy;
        logic        tm, th;
        bus.sayi1 = 32'h4040_0000;
        bus.sayi2 = 32'h3F80_0000;
        bus.basla = 1'b1;
        @(posedge clk);
        #1;
        bus.basla = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.sonuc !== 32'h0) begin errors++; $display("FAIL abort_sonuc: got %h expected 00000000", bus.sonuc); end
        checks++;
        if (bus.mesgul !== 1'b0) begin errors++; $display("FAIL abort_mesgul: got %b expected 0", bus.mesgul); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.hazir === 1'b1) hz++;
        end
        checks++;
        if (hz != 0) begin errors++; $display("FAIL abort_hazir: got %0d expected 0", hz); end
        run_op(32'h4000_0000, 32'h3F80_0000, res, lat, busy, tm, th);
        checks++;
        if (res !== 32'h4040_0000) begin errors++; $display("FAIL abort_next_sum: got %h expected 40400000", res); end
        checks++;
        if (lat != 6) begin errors++; $display("FAIL abort_next_latency: got %0d expected 6", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_special();
        test_denormal();
        test_ignore_basla();
        test_basla_at_hazir();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
